// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// Accepts one 128-bit state, transforms COLS_PER_CYCLE columns per clock,
// and holds the result until the downstream handshake completes.
//
// state | meaning
// IDLE  | empty, ready for a new state
// BUSY  | transforming column groups, counter selects the group
// DONE  | result valid in the work register, waiting for outReady
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] stateIn,
  input  logic         inverse,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] stateOut
);

  localparam int N  = 4 / COLS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [127:0]  work_q, work_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse matrix; row 0 is the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] acc;
    logic [31:0] res;
    res = '0;
    for (int j = 0; j < 4; j++) begin
      a[j]  = col[31-8*j -: 8];
      x2[j] = xtime(a[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
    end
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        // coefficient position within the rotated row
        case ((j - r + 4) % 4)
          0:       acc ^= inv ? (x8[j] ^ x4[j] ^ x2[j]) : x2[j];
          1:       acc ^= inv ? (x8[j] ^ x2[j] ^ a[j])  : (x2[j] ^ a[j]);
          2:       acc ^= inv ? (x8[j] ^ x4[j] ^ a[j])  : a[j];
          default: acc ^= inv ? (x8[j] ^ a[j])          : a[j];
        endcase
      end
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  assign inReady  = (state_q == S_IDLE) || ((state_q == S_DONE) && outReady);
  assign outValid = (state_q == S_DONE);
  assign stateOut = work_q;

  // Next-state logic: acceptance, per-group transform, and output handshake.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (inValid) begin
          work_d  = stateIn;
          mode_d  = inverse;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int c = 0; c < 4; c++) begin
          if ((c / COLS_PER_CYCLE) == int'(cnt_q)) begin
            work_d[32*c +: 32] = mix_col(work_q[32*c +: 32], mode_q);
          end
        end
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (outReady) begin
          if (inValid) begin
            work_d  = stateIn;
            mode_d  = inverse;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
